fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the single-cycle RV32I core.
- Holds the PC and issues requests to instruction memory, tolerating memory wait states.
- Presents the instruction to the decode/controller path, then consumes that path's next-PC select, Ecall and Ebreak outputs to form the next PC.
- Handles halt on EBREAK and redirect to a fixed trap vector on ECALL or a misaligned target.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on ECALL or misaligned-target trap.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  2  next-PC select: 00 PC+4, 01 PCTarget, 10 ALUResult with bit0 cleared (JALR), 11 reserved (treated as 00).
- PCTarget  in  XLEN  branch/JAL target from the datapath adder.
- ALUResult  in  XLEN  JALR target from the ALU.
- Ecall  in  1  current instruction is ECALL.
- Ebreak  in  1  current instruction is EBREAK.
- Resume  in  1  one-cycle pulse that leaves HALT.
- ImemReq  out  1  fetch request to instruction memory.
- ImemAddr  out  XLEN  fetch address (= PC).
- ImemRdata  in  32  instruction word, valid when ImemReady=1.
- ImemReady  in  1  memory response for the current request.
- Instr  out  32  instruction to decode; equals ImemRdata while InstrValid=1, otherwise 32'h0000_0013 (NOP).
- PC  out  XLEN  current PC.
- PCPlus4  out  XLEN  PC+4 (modulo 2^XLEN).
- InstrValid  out  1  high in the cycle the datapath may commit (register/memory write enable qualifier).
- EPC  out  XLEN  PC of the last trapping instruction.
- TrapCause  out  2  00 none, 01 ECALL, 10 misaligned target; holds until the next trap.
- Halted  out  1  high in HALT.

Behaviour:
- State machine: IDLE, FETCH, HALT. Reset is synchronous and active-high, and wins over every other input.
- On reset: state=IDLE, PC=RESET_PC, EPC=0, TrapCause=00, ImemReq=0, InstrValid=0, Halted=0.
- IDLE: ImemReq=0 for exactly one cycle after reset deasserts, then go to FETCH.
- FETCH: ImemReq=1 and ImemAddr=PC continuously.
  - InstrValid = ImemReady, combinational, so decode sees the instruction in the same cycle.
  - While ImemReady=0: PC holds, and no other register changes.
- On a rising edge with ImemReady=1, the first matching rule applies:
  - Ebreak=1: state to HALT, PC unchanged (points at the EBREAK).
  - Ecall=1: EPC=PC, TrapCause=01, PC=TRAP_VEC.
  - Candidate next PC has bits[1:0]!=0: EPC=PC, TrapCause=10, PC=TRAP_VEC. Applies to PCSrc=01 or 10, checked after the JALR bit0 clear.
  - Otherwise: PC = candidate selected by PCSrc.
- HALT: ImemReq=0, InstrValid=0, Halted=1, and PC/EPC/TrapCause hold. On Resume=1: PC=PC+4, state to FETCH.
- Resume outside HALT is ignored.
- Ecall and Ebreak asserted together: Ebreak wins.
- Ecall, Ebreak and PCSrc are sampled only while InstrValid=1; they are ignored in IDLE, in HALT, and during wait states.
- PC arithmetic wraps modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- Reset asserted mid-wait or in HALT: the next edge returns to reset values.
- Latency: one instruction per cycle with zero-wait memory; N wait cycles stretch a fetch to N+1 cycles.

Test Plan:
- Reset, zero-wait memory, PCSrc=00 -> ImemReq low in cycle 1; PC sequence 0x0, 0x4, 0x8 on consecutive cycles; InstrValid=1 each cycle.
- PC=0x10, PCSrc=01, PCTarget=0x40, ImemReady low 2 cycles then high -> PC holds 0x10 for 3 cycles, InstrValid=1 only in the third, then PC=0x40.
- PC=0x20, PCSrc=10, ALUResult=0x81 -> PC=0x80. ALUResult=0x82 -> PC=0x100, EPC=0x20, TrapCause=10.
- PC=0x30, Ecall=1 -> PC=0x100, EPC=0x30, TrapCause=01. Same cycle with Ebreak=1 as well -> HALT instead, PC=0x30, TrapCause unchanged.
- In HALT at PC=0x30: Resume pulse -> Halted=0, PC=0x34, fetch restarts. Resume with Halted=0 -> no effect.
- Reset asserted during a wait state at PC=0x44 -> next cycle PC=0x0, state IDLE, EPC=0, TrapCause=00, ImemReq=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage of the single-cycle
// RV32I core. It owns the PC, requests instructions from a memory that may
// insert wait states, and forms the next PC from the decode path's select,
// Ecall and Ebreak outputs. EBREAK halts the stage. ECALL and misaligned
// control-flow targets redirect to a fixed trap vector.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            Ecall,
    input  logic            Ebreak,
    input  logic            Resume,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic [31:0]     ImemRdata,
    input  logic            ImemReady,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrValid,
    output logic [XLEN-1:0] EPC,
    output logic [1:0]      TrapCause,
    output logic            Halted
);

    // addi x0, x0, 0: decode sees this whenever no real instruction is present
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] SEL_PLUS4  = 2'b00;
    localparam logic [1:0] SEL_TARGET = 2'b01;
    localparam logic [1:0] SEL_JALR   = 2'b10;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_ECALL     = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_reg;
    logic [XLEN-1:0] epc_next;
    logic [1:0]      cause_reg;
    logic [1:0]      cause_next;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] candidate_pc;
    logic            redirect_sel;
    logic            misaligned;
    logic            commit;
    logic            imem_req;
    logic            instr_valid;
    logic            halted;

    // The instruction commits in the cycle memory answers a live request;
    // every decision that depends on decode outputs is qualified by this.
    assign commit = (state_reg == ST_FETCH) && ImemReady;

    // FSM state register; reset wins over every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: one idle cycle after reset, halt on a committed EBREAK
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (commit && Ebreak) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request only while fetching, valid only on a memory response
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                imem_req    = 1'b1;
                instr_valid = ImemReady;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                imem_req    = 1'b0;
            end
        endcase
    end

    // Candidate next PC selected by the decode path; JALR drops bit 0 before
    // the alignment check so only a bad bit 1 can trap on that path.
    always_comb begin
        pc_plus4     = pc_reg + XLEN'(4);
        candidate_pc = pc_plus4;
        redirect_sel = 1'b0;
        case (PCSrc)
            SEL_TARGET: begin
                candidate_pc = PCTarget;
                redirect_sel = 1'b1;
            end
            SEL_JALR: begin
                candidate_pc = ALUResult & ~XLEN'(1);
                redirect_sel = 1'b1;
            end
            default: begin
                candidate_pc = pc_plus4;
                redirect_sel = 1'b0;
            end
        endcase
        misaligned = redirect_sel && (candidate_pc[1:0] != 2'b00);
    end

    // PC / EPC / cause update; priority EBREAK > ECALL > misaligned > normal.
    // Nothing moves during wait states, and HALT only advances on Resume.
    always_comb begin
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        cause_next = cause_reg;
        if (commit) begin
            if (Ebreak) begin
                pc_next = pc_reg;
            end else if (Ecall) begin
                epc_next   = pc_reg;
                cause_next = CAUSE_ECALL;
                pc_next    = TRAP_VEC;
            end else if (misaligned) begin
                epc_next   = pc_reg;
                cause_next = CAUSE_MISALIGN;
                pc_next    = TRAP_VEC;
            end else begin
                pc_next = candidate_pc;
            end
        end else if ((state_reg == ST_HALT) && Resume) begin
            pc_next = pc_plus4;
        end
    end

    // Architectural registers of the stage
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            epc_reg   <= '0;
            cause_reg <= CAUSE_NONE;
        end else begin
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            cause_reg <= cause_next;
        end
    end

    assign ImemReq    = imem_req;
    assign ImemAddr   = pc_reg;
    assign InstrValid = instr_valid;
    assign Instr      = instr_valid ? ImemRdata : NOP_INSTR;
    assign PC         = pc_reg;
    assign PCPlus4    = pc_plus4;
    assign EPC        = epc_reg;
    assign TrapCause  = cause_reg;
    assign Halted     = halted;

    // SEL_PLUS4 is the default arm above; kept named for readability
    logic unused_sel;
    assign unused_sel = (PCSrc == SEL_PLUS4);

endmodule
